// File: rtl/arc_pkg.sv
// Shared types and constants for the midpoint-circle arc engine.
// Optional screen clipping is enabled by defining ARC_PLOTTER_CLIP_EN.
package arc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLOT = 2'd1,
        STEP = 2'd2,
        DONE = 2'd3
    } arc_state_e;

    localparam logic [2:0] OCT_0 = 3'd0;
    localparam logic [2:0] OCT_1 = 3'd1;
    localparam logic [2:0] OCT_2 = 3'd2;
    localparam logic [2:0] OCT_3 = 3'd3;
    localparam logic [2:0] OCT_4 = 3'd4;
    localparam logic [2:0] OCT_5 = 3'd5;
    localparam logic [2:0] OCT_6 = 3'd6;
    localparam logic [2:0] OCT_7 = 3'd7;

    localparam int ARC_SCREEN_W = 160;
    localparam int ARC_SCREEN_H = 120;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/arc_octant_map.sv
// Maps the current (ox, oy) offset and octant index onto a signed screen pixel,
// and reports whether that pixel lies on the visible screen.
module arc_octant_map
    import arc_pkg::*;
#(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int R_W      = 8,
    parameter int SCREEN_W = ARC_SCREEN_W,
    parameter int SCREEN_H = ARC_SCREEN_H,
    localparam int CW      = R_W + 3,
    localparam int SW      = max_int(X_W, R_W) + 2
) (
    input  logic [X_W-1:0]       cx_i,
    input  logic [Y_W-1:0]       cy_i,
    input  logic signed [CW-1:0] ox_i,
    input  logic signed [CW-1:0] oy_i,
    input  logic [2:0]           oct_i,
    output logic signed [SW-1:0] px_o,
    output logic signed [SW-1:0] py_o,
    output logic                 in_bounds_o
);

    localparam logic [SW-1:0] X_LIM = SW'(SCREEN_W);
    localparam logic [SW-1:0] Y_LIM = SW'(SCREEN_H);

    logic signed [SW-1:0] cx_s;
    logic signed [SW-1:0] cy_s;
    logic signed [SW-1:0] a;
    logic signed [SW-1:0] b;

    assign cx_s = $signed({{(SW-X_W){1'b0}}, cx_i});
    assign cy_s = $signed({{(SW-Y_W){1'b0}}, cy_i});
    assign a    = SW'(ox_i);
    assign b    = SW'(oy_i);

    always_comb begin
        px_o = cx_s;
        py_o = cy_s;
        case (oct_i)
            OCT_0: begin px_o = cx_s + a; py_o = cy_s + b; end
            OCT_1: begin px_o = cx_s + b; py_o = cy_s + a; end
            OCT_2: begin px_o = cx_s - a; py_o = cy_s + b; end
            OCT_3: begin px_o = cx_s - b; py_o = cy_s + a; end
            OCT_4: begin px_o = cx_s - a; py_o = cy_s - b; end
            OCT_5: begin px_o = cx_s - b; py_o = cy_s - a; end
            OCT_6: begin px_o = cx_s + a; py_o = cy_s - b; end
            OCT_7: begin px_o = cx_s + b; py_o = cy_s - a; end
            default: begin px_o = cx_s; py_o = cy_s; end
        endcase
    end

    // Sign bit clear first, so the unsigned limit compares are valid.
    assign in_bounds_o = !px_o[SW-1] && !py_o[SW-1]
                       && ($unsigned(px_o) < X_LIM)
                       && ($unsigned(py_o) < Y_LIM);

endmodule

// File: rtl/arc_plotter.sv
// Midpoint-circle arc engine: one pixel per PLOT cycle for each enabled octant.
// Define ARC_PLOTTER_CLIP_EN to suppress plot strobes for off-screen pixels.
module arc_plotter
    import arc_pkg::*;
#(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int R_W      = 8,
    parameter int SCREEN_W = ARC_SCREEN_W,
    parameter int SCREEN_H = ARC_SCREEN_H
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [X_W-1:0]   centre_x,
    input  logic [Y_W-1:0]   centre_y,
    input  logic [R_W-1:0]   radius,
    input  logic [7:0]       octant_mask,
    input  logic [2:0]       colour,
    output logic             done,
    output logic [X_W-1:0]   vga_x,
    output logic [Y_W-1:0]   vga_y,
    output logic [2:0]       vga_colour,
    output logic             vga_plot,
    output arc_state_e       dbg_state_o
);

    localparam int CW = R_W + 3;
    localparam int SW = max_int(X_W, R_W) + 2;
    localparam logic signed [CW-1:0] ONE  = CW'(1);
    localparam logic signed [CW-1:0] ZERO = '0;

    arc_state_e           state_q, state_d;
    logic [X_W-1:0]       cx_q, cx_d;
    logic [Y_W-1:0]       cy_q, cy_d;
    logic [7:0]           mask_q, mask_d;
    logic [2:0]           colour_q, colour_d;
    logic signed [CW-1:0] ox_q, ox_d;
    logic signed [CW-1:0] oy_q, oy_d;
    logic signed [CW-1:0] crit_q, crit_d;
    logic [2:0]           oct_q, oct_d;

    logic signed [CW-1:0] step_ox, step_oy, step_crit;
    logic                 step_more;
    logic signed [SW-1:0] px, py;
    logic                 in_bounds;
    logic                 unused_bits;

    arc_octant_map #(
        .X_W(X_W), .Y_W(Y_W), .R_W(R_W), .SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H)
    ) u_map (
        .cx_i(cx_q), .cy_i(cy_q), .ox_i(ox_q), .oy_i(oy_q), .oct_i(oct_q),
        .px_o(px), .py_o(py), .in_bounds_o(in_bounds)
    );

    assign unused_bits = ^{px[SW-1:X_W], py[SW-1:Y_W], in_bounds};

    // One midpoint step: the decision variable uses the already-advanced ox/oy.
    always_comb begin
        step_ox = ox_q + ONE;
        if (crit_q <= ZERO) begin
            step_oy   = oy_q;
            step_crit = crit_q + (step_ox <<< 1) + ONE;
        end else begin
            step_oy   = oy_q - ONE;
            step_crit = crit_q + ((step_ox - step_oy) <<< 1) + ONE;
        end
        step_more = (step_oy >= step_ox);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = PLOT;
            PLOT:    if (oct_q == OCT_7) state_d = STEP;
            STEP:    state_d = step_more ? PLOT : DONE;
            DONE:    if (!start) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        done        = (state_q == DONE);
        vga_plot    = 1'b0;
        vga_x       = '0;
        vga_y       = '0;
        vga_colour  = '0;
        dbg_state_o = state_q;
        if (state_q == PLOT) begin
            vga_x      = px[X_W-1:0];
            vga_y      = py[Y_W-1:0];
            vga_colour = colour_q;
`ifdef ARC_PLOTTER_CLIP_EN
            vga_plot   = mask_q[oct_q] && in_bounds;
`else
            vga_plot   = mask_q[oct_q];
`endif
        end
    end

    always_comb begin
        cx_d     = cx_q;
        cy_d     = cy_q;
        mask_d   = mask_q;
        colour_d = colour_q;
        ox_d     = ox_q;
        oy_d     = oy_q;
        crit_d   = crit_q;
        oct_d    = oct_q;
        case (state_q)
            IDLE: if (start) begin
                cx_d     = centre_x;
                cy_d     = centre_y;
                mask_d   = octant_mask;
                colour_d = colour;
                ox_d     = ZERO;
                oy_d     = $signed({3'b000, radius});
                crit_d   = ONE - $signed({3'b000, radius});
                oct_d    = OCT_0;
            end
            PLOT: oct_d = oct_q + 3'd1;
            STEP: begin
                ox_d   = step_ox;
                oy_d   = step_oy;
                crit_d = step_crit;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cx_q     <= '0;
            cy_q     <= '0;
            mask_q   <= '0;
            colour_q <= '0;
            ox_q     <= '0;
            oy_q     <= '0;
            crit_q   <= '0;
            oct_q    <= '0;
        end else begin
            cx_q     <= cx_d;
            cy_q     <= cy_d;
            mask_q   <= mask_d;
            colour_q <= colour_d;
            ox_q     <= ox_d;
            oy_q     <= oy_d;
            crit_q   <= crit_d;
            oct_q    <= oct_d;
        end
    end

endmodule

// File: tb/tb_arc_plotter.sv
// Directed and random arcs checked pulse-by-pulse (cycle, x, y, colour) against
// an integer midpoint-circle model; ARC_PLOTTER_CLIP_EN selects the clipped model.
module tb_arc_plotter;
    import arc_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] centre_x;
    logic [6:0] centre_y;
    logic [7:0] radius;
    logic [7:0] octant_mask;
    logic [2:0] colour;
    logic       done;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;
    arc_state_e dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    bit seen_target;
    logic [33:0] exp_q[$];

    arc_plotter dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .centre_x(centre_x), .centre_y(centre_y), .radius(radius),
        .octant_mask(octant_mask), .colour(colour),
        .done(done), .vga_x(vga_x), .vga_y(vga_y),
        .vga_colour(vga_colour), .vga_plot(vga_plot), .dbg_state_o(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int wrapm(input int v, input int m);
        return ((v % m) + m) % m;
    endfunction

    // Expected pulses: {cycle after start edge, x, y, colour}, in draw order.
    task automatic build_model(input int cx, input int cy, input int r, input int mask,
                               input int col, output int n_iter);
        int ox, oy, d, dx, dy, x, y, it;
        bit show;
        exp_q.delete();
        ox = 0; oy = r; d = 1 - r; it = 0;
        while (oy >= ox) begin
            for (int k = 0; k < 8; k++) begin
                case (k)
                    0: begin dx =  ox; dy =  oy; end
                    1: begin dx =  oy; dy =  ox; end
                    2: begin dx = -ox; dy =  oy; end
                    3: begin dx = -oy; dy =  ox; end
                    4: begin dx = -ox; dy = -oy; end
                    5: begin dx = -oy; dy = -ox; end
                    6: begin dx =  ox; dy = -oy; end
                    default: begin dx = oy; dy = -ox; end
                endcase
                x = cx + dx;
                y = cy + dy;
                show = ((mask >> k) & 1) == 1;
`ifdef ARC_PLOTTER_CLIP_EN
                if (x < 0 || x >= 160 || y < 0 || y >= 120) show = 1'b0;
`endif
                if (show)
                    exp_q.push_back({16'(1 + 9 * it + k), 8'(wrapm(x, 256)),
                                     7'(wrapm(y, 128)), 3'(col)});
            end
            ox++;
            if (d <= 0) d += 2 * ox + 1;
            else begin oy--; d += 2 * (ox - oy) + 1; end
            it++;
        end
        n_iter = it;
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
    task automatic run_arc(input int cx, input int cy, input int r, input int mask,
                           input int col, input bit hold);
        int n_iter, k;
        bit got_done;
        logic [33:0] obs;
        build_model(cx, cy, r, mask, col, n_iter);
        centre_x = 8'(cx); centre_y = 7'(cy); radius = 8'(r);
        octant_mask = 8'(mask); colour = 3'(col);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = hold;
        centre_x = 8'($urandom); centre_y = 7'($urandom); radius = 8'($urandom);
        octant_mask = 8'($urandom); colour = 3'($urandom);
        k = 1; got_done = 1'b0;
        while (k <= 3000 && !got_done) begin
            if (vga_plot) begin
                obs = {16'(k), vga_x, vga_y, vga_colour};
                if (exp_q.size() == 0) chk("extra_pulse", obs, 64'h0);
                else                   chk("pulse", obs, exp_q.pop_front());
                if (vga_x == 8'd87 && vga_y == 7'd67) seen_target = 1'b1;
`ifdef ARC_PLOTTER_CLIP_EN
                chk("clip_on_screen", (vga_x < 8'd160 && vga_y < 7'd120), 1);
`endif
            end
            if (done) got_done = 1'b1;
            else begin @(negedge clk); k++; end
        end
        chk("done_cycle", k, 1 + 9 * n_iter);
        chk("missing_pulses", exp_q.size(), 0);
        if (hold) begin
            repeat (4) begin
                @(negedge clk);
                chk("hold_done", done, 1);
                chk("hold_no_plot", vga_plot, 0);
                chk("hold_state", dbg_state, DONE);
            end
            start = 1'b0;
        end
        @(negedge clk);
        chk("idle_done_low", done, 0);
        chk("idle_state", dbg_state, IDLE);
    endtask

    initial begin
        int cnt;
        rst_n = 1'b0; start = 1'b0;
        centre_x = '0; centre_y = '0; radius = '0; octant_mask = '0; colour = '0;
        repeat (3) @(negedge clk);
        chk("rst_done", done, 0);
        chk("rst_plot", vga_plot, 0);
        chk("rst_x", vga_x, 0);
        chk("rst_y", vga_y, 0);
        chk("rst_colour", vga_colour, 0);
        chk("rst_state", dbg_state, IDLE);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_state", dbg_state, IDLE);

        seen_target = 1'b0;
        run_arc(80, 60, 10, 'hFF, 2, 1'b0);
        chk("pixel_87_67", seen_target, 1);
        run_arc(80, 60, 10, 'h03, 5, 1'b0);
        run_arc(5, 5, 0, 'hFF, 1, 1'b0);
        run_arc(2, 2, 10, 'hFF, 4, 1'b0);
        run_arc(40, 30, 6, 'hA5, 3, 1'b1);
        run_arc(50, 50, 8, 'hFF, 7, 1'b0);
        run_arc(0, 0, 255, 'h81, 6, 1'b0);

        for (int i = 0; i < 12; i++)
            run_arc($urandom_range(0, 255), $urandom_range(0, 127), $urandom_range(0, 40),
                    $urandom_range(0, 255), $urandom_range(0, 7), 1'($urandom_range(0, 1)));

        // Reset in the middle of a draw.
        centre_x = 8'd80; centre_y = 7'd60; radius = 8'd10;
        octant_mask = 8'hFF; colour = 3'd6; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        chk("mid_state", dbg_state, PLOT);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_plot", vga_plot, 0);
        chk("mid_rst_x", vga_x, 0);
        chk("mid_rst_y", vga_y, 0);
        chk("mid_rst_colour", vga_colour, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_state", dbg_state, IDLE);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        repeat (30) begin
            @(negedge clk);
            if (vga_plot || done) cnt++;
        end
        chk("after_rst_quiet", cnt, 0);
        chk("after_rst_state", dbg_state, IDLE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
